// File: rtl/prog_loader.sv
// prog_loader: packs a valid/ready byte stream into little-endian words, writes them to RAM and holds the CPU in reset until the image is loaded (optional PROG_LOADER_CHECKSUM_EN adds a trailing 32-bit checksum stage)
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAX_WORDS = 32'd64
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        busy,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        cpu_rst,
  output logic        err,
  output logic [15:0] words_done
);
`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR} state_t;
  localparam state_t S_TAIL = S_CSUM;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif
  state_t      r_state, w_next;
  logic [1:0]  r_bidx;
  logic [31:0] r_word, r_count, r_addr, r_wdata;
  logic [15:0] r_words_done;
  logic        r_err;
  logic        w_take, w_fire, w_last_word;
  logic [31:0] w_full;
  logic        w_sum_ok;
  // w_take marks the 4th byte of a group; only meaningful in states that accept bytes
  assign w_take      = clk_en & rx_valid & (r_bidx == 2'd3);
  assign w_fire      = clk_en & rx_valid & rx_ready;
  assign w_full      = {rx_data, r_word[31:8]};
  assign w_last_word = ({16'd0, r_words_done} + 32'd1) == r_count;
  assign busy        = r_state != S_DONE;
  assign cpu_rst     = r_state != S_DONE;
  assign mem_wr_en   = r_state == S_WRITE;
  assign mem_addr    = r_addr;
  assign mem_w_data  = r_wdata;
  assign err         = r_err;
  assign words_done  = r_words_done;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
  assign w_sum_ok = w_full == r_sum;
  // running modulo-2^32 sum of every word written in this load
  always_ff @(posedge clk_100M or negedge rst_n)
    if (!rst_n) r_sum <= '0;
    else if (clk_en) begin
      if (r_state == S_WRITE) r_sum <= r_sum + r_wdata;
      if (w_next == S_LEN && r_state != S_LEN) r_sum <= '0;
    end
`else
  assign w_sum_ok = 1'b0;
`endif
  // state register
  always_ff @(posedge clk_100M or negedge rst_n)
    if (!rst_n) r_state <= S_LEN;
    else r_state <= w_next;
  // next-state and byte-acceptance decode
  always_comb begin
    w_next   = r_state;
    rx_ready = 1'b0;
    case (r_state)
      S_LEN: begin
        rx_ready = 1'b1;
        if (w_take) w_next = w_full == 32'd0 ? S_TAIL : (w_full > MAX_WORDS ? S_ERROR : S_DATA);
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (w_take) w_next = S_WRITE;
      end
      S_WRITE: if (clk_en) w_next = w_last_word ? S_TAIL : S_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (w_take) w_next = w_sum_ok ? S_DONE : S_ERROR;
      end
`endif
      S_DONE, S_ERROR: if (clk_en && load_req) w_next = S_LEN;
      default: w_next = S_LEN;
    endcase
  end
  // byte packing, write address/data, progress counter and sticky error
  always_ff @(posedge clk_100M or negedge rst_n)
    if (!rst_n) begin
      r_bidx       <= '0;
      r_word       <= '0;
      r_count      <= '0;
      r_addr       <= BASE_ADDR;
      r_wdata      <= '0;
      r_words_done <= '0;
      r_err        <= 1'b0;
    end else if (clk_en) begin
      if (w_fire) begin
        r_word <= w_full;
        r_bidx <= r_bidx + 2'd1;
      end
      if (r_state == S_LEN && w_take) r_count <= w_full;
      if (r_state == S_DATA && w_take) r_wdata <= w_full;
      if (r_state == S_WRITE) begin
        r_addr       <= r_addr + 32'd4;
        r_words_done <= r_words_done + 16'd1;
      end
      if (w_next == S_ERROR) r_err <= 1'b1;
      if (w_next == S_LEN && r_state != S_LEN) begin
        r_addr       <= BASE_ADDR;
        r_words_done <= '0;
        r_bidx       <= '0;
        r_err        <= 1'b0;
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed tests for prog_loader
module tb_prog_loader;
  logic        clk_100M = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        load_req = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, busy, mem_wr_en, cpu_rst, err;
  logic [31:0] mem_addr, mem_w_data;
  logic [15:0] words_done;
  int          checks = 0;
  int          errors = 0;
  bit          rand_en = 1'b0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  prog_loader dut (
    .clk_100M(clk_100M), .rst_n(rst_n), .clk_en(clk_en), .load_req(load_req),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .cpu_rst(cpu_rst), .err(err), .words_done(words_done)
  );

  always #5 clk_100M = ~clk_100M;

  always @(negedge clk_100M) clk_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;

  // records every write that the next rising edge commits
  always @(negedge clk_100M) begin
    #1;
    if (rst_n && mem_wr_en && clk_en) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_w_data);
    end
  end

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return i < q.size() ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic settle;
    @(negedge clk_100M);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit fired = 1'b0;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clk_100M);
      if (rand_en && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
      end
      #1 fired = rx_valid && clk_en && rx_ready;
      @(posedge clk_100M);
      #1 rx_valid = 1'b0;
    end
    if (!fired) begin
      checks++;
      errors++;
      $display("FAIL send_byte: byte %h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // load_req pulse with a competing byte offered; the byte must not be consumed
  task automatic load_pulse;
    @(negedge clk_100M);
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    @(posedge clk_100M);
    #1;
    load_req = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk_100M);
    #1;
    checks++; if ({rx_ready, busy, cpu_rst, mem_wr_en, err} !== 5'b11100) begin errors++; $display("FAIL reset_flags: got %b want 11100", {rx_ready, busy, cpu_rst, mem_wr_en, err}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    checks++; if (mem_w_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mem_w_data); end
    checks++; if (words_done !== 16'h0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_done); end
    @(negedge clk_100M);
    rst_n = 1'b1;
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    wa.delete(); wd.delete();
    send_word(32'd2); send_word(32'h1234_5678); send_word(32'hDEAD_BEEF);
    settle;
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL csum_wait: cpu_rst got %b want 1", cpu_rst); end
    send_word(32'hF0E2_1567);
    settle;
    checks++; if ({cpu_rst, err, busy} !== 3'b000) begin errors++; $display("FAIL csum_ok: {cpu_rst,err,busy} got %b want 000", {cpu_rst, err, busy}); end
    checks++; if (wa.size() != 2 || qget(wd, 1) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL csum_writes: count %0d last %h want 2 deadbeef", wa.size(), qget(wd, 1)); end
    load_pulse;
    send_word(32'd2); send_word(32'h1234_5678); send_word(32'hDEAD_BEEF); send_word(32'h0);
    settle;
    checks++; if ({cpu_rst, err, busy, rx_ready} !== 4'b1110) begin errors++; $display("FAIL csum_bad: {cpu_rst,err,busy,rx_ready} got %b want 1110", {cpu_rst, err, busy, rx_ready}); end
    load_pulse;
    settle;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL csum_clear: err got %b want 0", err); end
    send_word(32'd0); send_word(32'd0);
    settle;
    checks++; if ({cpu_rst, err} !== 2'b00) begin errors++; $display("FAIL csum_zero: {cpu_rst,err} got %b want 00", {cpu_rst, err}); end
  endtask
`else
  task automatic test_basic;
    wa.delete(); wd.delete();
    send_word(32'd2); send_word(32'h1234_5678);
    settle;
    checks++; if ({mem_wr_en, mem_addr, mem_w_data} !== {1'b1, 32'h0, 32'h1234_5678}) begin errors++; $display("FAIL basic_w0: en %b addr %h data %h want 1 0 12345678", mem_wr_en, mem_addr, mem_w_data); end
    send_word(32'hDEAD_BEEF);
    settle;
    checks++; if ({mem_wr_en, cpu_rst, mem_addr, mem_w_data} !== {2'b11, 32'h4, 32'hDEAD_BEEF}) begin errors++; $display("FAIL basic_w1: en %b rst %b addr %h data %h want 1 1 4 deadbeef", mem_wr_en, cpu_rst, mem_addr, mem_w_data); end
    settle;
    checks++; if ({cpu_rst, busy, rx_ready, mem_wr_en} !== 4'b0000) begin errors++; $display("FAIL basic_done: {cpu_rst,busy,rx_ready,wr} got %b want 0000", {cpu_rst, busy, rx_ready, mem_wr_en}); end
    checks++; if (words_done !== 16'd2) begin errors++; $display("FAIL basic_words: got %0d want 2", words_done); end
    checks++; if (wa.size() != 2 || qget(wa, 1) !== 32'h4 || qget(wd, 0) !== 32'h1234_5678) begin errors++; $display("FAIL basic_log: count %0d addr1 %h data0 %h want 2 4 12345678", wa.size(), qget(wa, 1), qget(wd, 0)); end
  endtask

  task automatic test_zero;
    load_pulse;
    settle;
    checks++; if ({rx_ready, cpu_rst, err} !== 3'b110 || words_done !== 16'd0 || mem_addr !== 32'h0) begin errors++; $display("FAIL reload: {rdy,rst,err} %b words %0d addr %h want 110 0 0", {rx_ready, cpu_rst, err}, words_done, mem_addr); end
    wa.delete(); wd.delete();
    send_word(32'd0);
    settle;
    checks++; if ({cpu_rst, busy} !== 2'b00) begin errors++; $display("FAIL zero_done: {cpu_rst,busy} got %b want 00", {cpu_rst, busy}); end
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_error;
    load_pulse;
    wa.delete(); wd.delete();
    send_word(32'd65);
    settle;
    checks++; if ({err, cpu_rst, busy, rx_ready} !== 4'b1110) begin errors++; $display("FAIL err_state: {err,rst,busy,rdy} got %b want 1110", {err, cpu_rst, busy, rx_ready}); end
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL err_writes: got %0d want 0", wa.size()); end
    load_pulse;
    settle;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    send_word(32'd1); send_word(32'hDDCC_BBAA);
    settle; settle;
    checks++; if (wa.size() != 1 || qget(wa, 0) !== 32'h0 || qget(wd, 0) !== 32'hDDCC_BBAA || cpu_rst !== 1'b0) begin errors++; $display("FAIL err_reload: count %0d addr %h data %h rst %b want 1 0 ddccbbaa 0", wa.size(), qget(wa, 0), qget(wd, 0), cpu_rst); end
  endtask

  task automatic test_stall;
    logic [31:0] img [3] = '{32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h8001_7FFE};
    load_pulse;
    wa.delete(); wd.delete();
    rand_en = 1'b1;
    send_word(32'd3);
    for (int i = 0; i < 3; i++) send_word(img[i]);
    for (int i = 0; i < 200 && cpu_rst; i++) settle;
    rand_en = 1'b0;
    settle;
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL stall_done: cpu_rst got %b want 0", cpu_rst); end
    checks++; if (wa.size() != 3) begin errors++; $display("FAIL stall_count: got %0d want 3", wa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (qget(wa, i) !== 32'(4 * i) || qget(wd, i) !== img[i]) begin errors++; $display("FAIL stall_w%0d: addr %h data %h want %h %h", i, qget(wa, i), qget(wd, i), 32'(4 * i), img[i]); end
    end
  endtask

  task automatic test_reset_mid;
    load_pulse;
    wa.delete(); wd.delete();
    send_word(32'd2); send_word(32'h1122_3344);
    send_byte(8'h55); send_byte(8'h66);
    @(negedge clk_100M);
    rst_n = 1'b0;
    #1;
    checks++; if ({rx_ready, busy, cpu_rst, mem_wr_en, err} !== 5'b11100 || mem_addr !== 32'h0 || mem_w_data !== 32'h0 || words_done !== 16'd0) begin errors++; $display("FAIL mid_reset: flags %b addr %h data %h words %0d want 11100 0 0 0", {rx_ready, busy, cpu_rst, mem_wr_en, err}, mem_addr, mem_w_data, words_done); end
    settle; settle;
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL mid_writes: got %0d want 1", wa.size()); end
    @(negedge clk_100M);
    rst_n = 1'b1;
    wa.delete(); wd.delete();
    send_word(32'd1); send_word(32'hA5A5_5A5A);
    settle; settle;
    checks++; if (wa.size() != 1 || qget(wa, 0) !== 32'h0 || qget(wd, 0) !== 32'hA5A5_5A5A || cpu_rst !== 1'b0) begin errors++; $display("FAIL mid_reload: count %0d addr %h data %h rst %b want 1 0 a5a55a5a 0", wa.size(), qget(wa, 0), qget(wd, 0), cpu_rst); end
  endtask
`endif

  initial begin
    test_reset;
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum;
`else
    test_basic;
    test_zero;
    test_error;
    test_stall;
    test_reset_mid;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
